// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The producer/consumer side uses master; the subtractor uses slave.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow, ovf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first, one bit
// per clock with a single registered borrow. Valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for operands, in_ready = 1
// SHIFT | one difference bit per edge, WIDTH edges
// DONE  | result held until out_ready
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  // Holds the WIDTH-1 most recent difference bits; the LSB drops out on the final shift.
  logic [WIDTH-2:0] r_res_sh;
  logic             r_bor;
  logic [CW-1:0]    r_cnt;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_ovf;
  logic             r_out_valid;

  logic             w_d;
  logic             w_bor_nxt;
  logic [WIDTH-1:0] w_res_nxt;

  assign w_d       = r_a_sh[0] ^ r_b_sh[0] ^ r_bor;
  assign w_bor_nxt = (~r_a_sh[0] & r_b_sh[0]) | (~(r_a_sh[0] ^ r_b_sh[0]) & r_bor);
  assign w_res_nxt = {w_d, r_res_sh};

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.diff      = r_diff;
  assign bus.borrow    = r_borrow;
  assign bus.ovf       = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_res_sh    <= '0;
      r_bor       <= 1'b0;
      r_cnt       <= '0;
      r_a_msb     <= 1'b0;
      r_b_msb     <= 1'b0;
      r_diff      <= '0;
      r_borrow    <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a_sh   <= bus.a;
            r_b_sh   <= bus.b;
            r_a_msb  <= bus.a[WIDTH-1];
            r_b_msb  <= bus.b[WIDTH-1];
            r_bor    <= 1'b0;
            r_cnt    <= '0;
            r_res_sh <= '0;
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          r_bor    <= w_bor_nxt;
          r_res_sh <= w_res_nxt[WIDTH-1:1];
          r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_diff      <= w_res_nxt;
            r_borrow    <= w_bor_nxt;
            r_ovf       <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: driver pushes expected results,
// a negedge monitor pops and compares whenever a result is handed over.
module tb_serial_subtractor;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
  } res_t;

  res_t sb_q[$];

  serial_subtractor_if #(.WIDTH(W)) bus ();
  serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timeout waiting for DUT at %0t", name, $time);
  endtask

  // Monitor: a result is consumed on any edge where out_valid & out_ready.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got %h expected none", {bus.diff, bus.borrow, bus.ovf});
      end else begin
        res_t e;
        e = sb_q.pop_front();
        check("diff", 32'(bus.diff), 32'(e.diff));
        check("borrow", 32'(bus.borrow), 32'(e.borrow));
        check("ovf", 32'(bus.ovf), 32'(e.ovf));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!bus.in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) timeout("wait_idle");
  endtask

  // mode 0: normal, 1: backpressure 5 cycles, 2: busy pulses and operand changes mid-shift
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ed, input logic eb, input logic eo, input int mode);
    int n;
    logic [W-1:0] hold_d;
    logic hold_b;
    wait_idle();
    bus.out_ready = (mode != 1);
    bus.a = a;
    bus.b = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    sb_q.push_back('{diff: ed, borrow: eb, ovf: eo});
    n = 0;
    while (!bus.out_valid && n < 20) begin
      if (mode == 2 && n == 2) begin
        bus.in_valid = 1'b1;
        bus.a = 8'hAA;
        bus.b = 8'h55;
      end
      if (mode == 2 && n == 5) bus.in_valid = 1'b0;
      @(posedge clk); #1;
      n++;
      if (n < W) check("in_ready_busy", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    if (!bus.out_valid) timeout("out_valid");
    else check("latency", 32'(n), 32'(W));
    if (mode == 1) begin
      hold_d = bus.diff;
      hold_b = bus.borrow;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #1;
        check("bp_valid", 32'(bus.out_valid), 32'd1);
        check("bp_diff", 32'(bus.diff), 32'(hold_d));
        check("bp_borrow", 32'(bus.borrow), 32'(hold_b));
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_valid_fall", 32'(bus.out_valid), 32'd0);
      check("bp_in_ready_rise", 32'(bus.in_ready), 32'd1);
    end
    if (mode == 2) begin
      @(posedge clk); #1;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk); #1;
        check("busy_no_extra", 32'(bus.out_valid), 32'd0);
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    #3;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_diff", 32'(bus.diff), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    #14 rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 0);
    do_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 0);
    do_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 0);
    do_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 0);
    do_op(8'h64, 8'h96, 8'hCE, 1'b1, 1'b1, 1);
    do_op(8'h3C, 8'h0F, 8'h2D, 1'b0, 1'b0, 2);
    do_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 0);
    @(posedge clk); #1;

    // Abort mid-shift: accept, then pull reset between edges in the 4th SHIFT cycle.
    wait_idle();
    bus.a = 8'h5A;
    bus.b = 8'h21;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_diff", 32'(bus.diff), 32'd0);
    check("abort_borrow", 32'(bus.borrow), 32'd0);
    check("abort_ovf", 32'(bus.ovf), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("abort_no_result", 32'(bus.out_valid), 32'd0);
    end

    do_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
